// File: rtl/uart_tx_unit_pkg.sv
// Shared UART definitions: transmitter FSM states and default timing/buffer constants.
package lib_uart;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} TX_STATE;

    localparam int UART_CLKS_PER_BIT = 868;
    localparam int UART_FIFO_DEPTH   = 4;

endpackage

// File: rtl/uart_tx_unit_fifo.sv
// Synchronous FIFO, head word visible on dout while not empty.
// Push into a full FIFO and pop from an empty one are ignored.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_unit.sv
// UART 8N1 transmitter with a small byte FIFO fed by the execute-stage I/O write strobe.
// First start bit two cycles after w_req; frames back-to-back while data is queued.
module uart_tx_unit
    import lib_uart::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = UART_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       w_req,
    input  logic [7:0] w_data,
    output logic       w_busy,
    output logic       tx,
    output logic       tx_idle,
    output logic       overflow,
    input  logic       ovf_clr
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CLKS_PER_BIT - 1);

    TX_STATE          state_q;
    logic [TMR_W-1:0] timer_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             w_busy_q;
    logic             tx_idle_q;
    logic             ovf_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_d;
    logic             push;
    logic             pop;
    logic             frame_end;
    logic             going_idle;

    // A write into a full FIFO is dropped even if a pop frees a slot that same edge.
    assign push       = w_req && !fifo_full;
    assign frame_end  = (state_q == TX_STOP) && (timer_q == '0);
    assign pop        = (state_q == TX_IDLE || frame_end) && !fifo_empty;
    assign going_idle = (state_q == TX_IDLE || frame_end) && fifo_empty;

    always_comb begin
        count_d = fifo_count;
        if (push && !pop)      count_d = fifo_count + CNT_W'(1);
        else if (pop && !push) count_d = fifo_count - CNT_W'(1);
    end

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (w_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_busy_q  <= 1'b0;
            tx_idle_q <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            w_busy_q  <= (count_d == CNT_W'(FIFO_DEPTH));
            tx_idle_q <= going_idle && (count_d == '0);
            if (w_req && fifo_full) ovf_q <= 1'b1;
            else if (ovf_clr)       ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= fifo_dout;
                        timer_q <= TMR_LOAD;
                        tx_q    <= 1'b0;
                        state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (timer_q == '0) begin
                        timer_q   <= TMR_LOAD;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= TX_DATA;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                TX_DATA: begin
                    if (timer_q == '0) begin
                        timer_q <= TMR_LOAD;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= TX_STOP;
                        end else begin
                            // Drive the next bit directly so the line changes on the boundary.
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                TX_STOP: begin
                    if (timer_q == '0) begin
                        if (pop) begin
                            shift_q <= fifo_dout;
                            timer_q <= TMR_LOAD;
                            tx_q    <= 1'b0;
                            state_q <= TX_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= TX_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx       = tx_q;
    assign w_busy   = w_busy_q;
    assign tx_idle  = tx_idle_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit: serial RX model scoreboards every frame on two instances
// (4 and 2 clocks per bit) while the main sequence checks timing, flags and reset behaviour.
module tb_uart_tx_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n_a, w_req_a, ovf_clr_a, w_busy_a, tx_a, tx_idle_a, ovf_a;
    logic [7:0] w_data_a;
    logic       rst_n_b, w_req_b, ovf_clr_b, w_busy_b, tx_b, tx_idle_b, ovf_b;
    logic [7:0] w_data_b;

    uart_tx_unit #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst_n(rst_n_a), .w_req(w_req_a), .w_data(w_data_a), .w_busy(w_busy_a),
        .tx(tx_a), .tx_idle(tx_idle_a), .overflow(ovf_a), .ovf_clr(ovf_clr_a)
    );

    uart_tx_unit #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n_b), .w_req(w_req_b), .w_data(w_data_b), .w_busy(w_busy_b),
        .tx(tx_b), .tx_idle(tx_idle_b), .overflow(ovf_b), .ovf_clr(ovf_clr_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: bytes expected on the wire, plus start-bit cycles seen on instance a.
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int         starts_a[$];
    int         rx_cnt[2];
    logic       rx_busy[2] = '{1'b0, 1'b0};
    logic [9:0] rx_sh[2];

    task automatic rx_step(input int sel, input logic line, input int cpb);
        int k;
        logic [7:0] want;
        if (!rx_busy[sel]) begin
            if (line === 1'b0) begin
                rx_busy[sel] = 1'b1;
                rx_cnt[sel]  = 0;
                if (sel == 0) starts_a.push_back(cyc);
            end
        end else begin
            rx_cnt[sel]++;
        end
        if (rx_busy[sel] && (rx_cnt[sel] % cpb) == cpb / 2) begin
            k = rx_cnt[sel] / cpb;
            rx_sh[sel][k] = line;
            if (k == 9) begin
                rx_busy[sel] = 1'b0;
                chk("rx_start_bit", rx_sh[sel][0], 1'b0);
                chk("rx_stop_bit", rx_sh[sel][9], 1'b1);
                if (sel == 0) begin
                    chk("rx_a_expected", exp_a.size() > 0, 1'b1);
                    want = (exp_a.size() > 0) ? exp_a.pop_front() : 8'h00;
                end else begin
                    chk("rx_b_expected", exp_b.size() > 0, 1'b1);
                    want = (exp_b.size() > 0) ? exp_b.pop_front() : 8'h00;
                end
                chk("rx_byte", rx_sh[sel][8:1], want);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n_a) rx_busy[0] = 1'b0;
        else          rx_step(0, tx_a, 4);
        if (!rst_n_b) rx_busy[1] = 1'b0;
        else          rx_step(1, tx_b, 2);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Caller is in the cycle before the expected start bit.
    task automatic expect_frame(input int sel, input logic [7:0] b, input int cpb, input string tag);
        logic want;
        for (int k = 0; k < 10 * cpb; k++) begin
            tick();
            smp();
            if (k < cpb)            want = 1'b0;
            else if (k >= 9 * cpb)  want = 1'b1;
            else                    want = b[k / cpb - 1];
            chk(tag, (sel == 0) ? tx_a : tx_b, want);
        end
    endtask

    task automatic wait_idle_a(input int max, output int at);
        for (int i = 0; i < max; i++) begin
            tick();
            smp();
            if (tx_idle_a === 1'b1) begin
                at = cyc;
                return;
            end
        end
        chk("wait_idle_timeout", tx_idle_a, 1'b1);
        at = cyc;
    endtask

    int t0;
    int at;

    initial begin
        rst_n_a = 1'b0; w_req_a = 1'b0; w_data_a = 8'h00; ovf_clr_a = 1'b0;
        rst_n_b = 1'b0; w_req_b = 1'b0; w_data_b = 8'h00; ovf_clr_b = 1'b0;
        repeat (3) tick();
        smp();
        chk("rst_tx", tx_a, 1'b1);
        chk("rst_busy", w_busy_a, 1'b0);
        chk("rst_idle", tx_idle_a, 1'b1);
        chk("rst_ovf", ovf_a, 1'b0);
        chk("rst_tx_b", tx_b, 1'b1);
        tick();
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        repeat (5) tick();

        // Single byte: start bit two cycles after the write, idle again 42 cycles after it.
        w_req_a = 1'b1; w_data_a = 8'h55; exp_a.push_back(8'h55); t0 = cyc;
        smp();
        chk("t1_idle_before", tx_idle_a, 1'b1);
        tick();
        w_req_a = 1'b0;
        smp();
        chk("t1_idle_drop", tx_idle_a, 1'b0);
        chk("t1_tx_pre", tx_a, 1'b1);
        expect_frame(0, 8'h55, 4, "t1_tx");
        tick();
        smp();
        chk("t1_idle_back", tx_idle_a, 1'b1);
        chk("t1_idle_cycle", cyc - t0, 42);

        // Five back-to-back writes fill the FIFO, then overflow and its clear.
        starts_a.delete();
        tick();
        t0 = cyc;
        for (int i = 0; i < 5; i++) begin
            w_req_a = 1'b1; w_data_a = 8'(i + 1); exp_a.push_back(8'(i + 1));
            smp();
            chk("t2_busy_fill", w_busy_a, 1'b0);
            tick();
        end
        w_data_a = 8'hAA;
        smp();
        chk("t2_busy_full", w_busy_a, 1'b1);
        chk("t2_no_ovf", ovf_a, 1'b0);
        tick();
        w_req_a = 1'b0; ovf_clr_a = 1'b1;
        smp();
        chk("t3_ovf_set", ovf_a, 1'b1);
        tick();
        w_req_a = 1'b1; w_data_a = 8'hAA;
        smp();
        chk("t3_ovf_clr", ovf_a, 1'b0);
        tick();
        w_req_a = 1'b0;
        smp();
        chk("t3_set_wins", ovf_a, 1'b1);
        chk("t3_busy_hold", w_busy_a, 1'b1);
        tick();
        ovf_clr_a = 1'b0;
        smp();
        chk("t3_ovf_clr2", ovf_a, 1'b0);
        wait_idle_a(400, at);
        chk("t2_total", at - t0, 202);
        chk("t2_nframes", starts_a.size(), 5);
        if (starts_a.size() == 5) begin
            chk("t2_first_start", starts_a[0] - t0, 2);
            for (int i = 1; i < 5; i++) chk("t2_gap", starts_a[i] - starts_a[i-1], 40);
        end

        // Push on the same edge that STOP pops the next byte.
        starts_a.delete();
        tick();
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            w_req_a = 1'b1; w_data_a = 8'hA1 + 8'(i); exp_a.push_back(8'hA1 + 8'(i));
            tick();
        end
        w_req_a = 1'b0;
        while (cyc < t0 + 41) tick();
        w_req_a = 1'b1; w_data_a = 8'hA5; exp_a.push_back(8'hA5);
        smp();
        chk("t4_busy_pre", w_busy_a, 1'b0);
        chk("t4_tx_stop", tx_a, 1'b1);
        tick();
        w_data_a = 8'hA6; exp_a.push_back(8'hA6);
        smp();
        chk("t4_busy_same", w_busy_a, 1'b0);
        chk("t4_tx_start", tx_a, 1'b0);
        chk("t4_not_idle", tx_idle_a, 1'b0);
        tick();
        w_req_a = 1'b0;
        smp();
        chk("t4_busy_full", w_busy_a, 1'b1);
        wait_idle_a(400, at);
        chk("t4_total", at - t0, 242);
        chk("t4_nframes", starts_a.size(), 6);
        if (starts_a.size() == 6) begin
            for (int i = 1; i < 6; i++) chk("t4_gap", starts_a[i] - starts_a[i-1], 40);
        end

        // Reset in the middle of a data bit that is low.
        tick();
        w_req_a = 1'b1; w_data_a = 8'h0F; exp_a.push_back(8'h0F);
        tick();
        w_req_a = 1'b0;
        repeat (22) tick();
        smp();
        chk("t5_tx_bit4", tx_a, 1'b0);
        #1;
        rst_n_a = 1'b0;
        #1;
        chk("t5_tx_async", tx_a, 1'b1);
        chk("t5_idle_async", tx_idle_a, 1'b1);
        chk("t5_busy_async", w_busy_a, 1'b0);
        smp();
        #1;
        rst_n_a = 1'b1;
        exp_a.delete();
        for (int i = 0; i < 60; i++) begin
            tick();
            smp();
            chk("t5_tx_quiet", tx_a, 1'b1);
        end
        chk("t5_idle_after", tx_idle_a, 1'b1);

        // Two clocks per bit, MSB-only byte.
        tick();
        w_req_b = 1'b1; w_data_b = 8'h80; exp_b.push_back(8'h80);
        tick();
        w_req_b = 1'b0;
        smp();
        chk("t6_tx_pre", tx_b, 1'b1);
        expect_frame(1, 8'h80, 2, "t6_tx");
        tick();
        smp();
        chk("t6_idle_back", tx_idle_b, 1'b1);

        repeat (4) tick();
        chk("sb_drain_a", exp_a.size(), 0);
        chk("sb_drain_b", exp_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
